// File: rtl/note_sequencer.sv
// note_sequencer: walks a {len, div} note table from a synchronous ROM
// and drives the tone generator, closing every note with a silent gap.
module note_sequencer #(
    parameter int unsigned TEMPO_TICKS = 9000000,
    parameter int unsigned GAP_TICKS   = 100000,
    parameter int unsigned NUM_NOTES   = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DIV_W       = 17,
    parameter int unsigned LEN_W       = 4,
    parameter bit          LOOP        = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [LEN_W+DIV_W-1:0] rom_data,
    output logic [DIV_W-1:0]       tone_div,
    output logic                   tone_en,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [31:0] TEMPO = 32'(TEMPO_TICKS);
    localparam logic [31:0] GAP   = 32'(GAP_TICKS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NOTES - 1);

    state_t           state;
    logic [31:0]      count;
    logic [LEN_W-1:0] len;
    logic [DIV_W-1:0] div;
    logic [31:0]      load_count;
    logic [31:0]      next_count;
    logic             song_end;

    assign {len, div}  = rom_data;
    assign load_count  = 32'(len) * TEMPO - 32'd1;
    assign next_count  = count - 32'd1;

    // End marker in LOAD, or the last PLAY cycle of the final entry.
    always_comb begin
        song_end = 1'b0;
        if (state == S_LOAD)
            song_end = (len == '0);
        else if (state == S_PLAY)
            song_end = (count == '0) && (rom_addr == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            tone_div <= '0;
            tone_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
        end else begin
            done    <= 1'b0;
            tone_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    rom_addr <= '0;
                    tone_div <= '0;
                    if (start) begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: state <= S_LOAD;
                S_LOAD: begin
                    if (len != '0) begin
                        tone_div <= div;
                        count    <= load_count;
                        tone_en  <= (div != '0) &&
                                    (load_count >= GAP);
                        state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (count != '0) begin
                        count   <= next_count;
                        tone_en <= (tone_div != '0) &&
                                   (next_count >= GAP);
                    end else if (rom_addr != LAST) begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    rom_addr <= '0;
                    tone_div <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (song_end) begin
                if (LOOP) begin
                    rom_addr <= '0;
                    state    <= S_WAIT;
                end else begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule
